add_share_arbiter: RTL and testbench

Round-robin scheduler that shares one registered `noOverflowAdd` adder among NUM_REQ requesters in the matrix-multiply accumulate path. It accepts at most one operand pair per cycle via valid/ready and issues it to the adder. It returns each sum tagged with the requester index after a fixed two-cycle latency. It sits between the per-row partial-product producers and the accumulation buffers.

---
 rtl/mmul_pkg.sv | 32 +++
 rtl/add_share_arbiter_rr_grant.sv | 36 +++
 rtl/noOverflowAdd.sv | 29 ++
 rtl/add_share_arbiter.sv | 132 +++++++++++++
 tb/tb_add_share_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmul_pkg.sv
// Shared definitions for the matrix-multiply accumulate path.
// Holds default operand/result widths and elaboration helper functions.
package mmul_pkg;

    localparam int WIDTH_A_DEF   = 32;
    localparam int WIDTH_B_DEF   = 32;
    localparam int RES_WIDTH_DEF = 37;

    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 16;

    // A sum of two unsigned operands needs one bit above the wider one.
    function automatic bit res_width_ok(
        input int wa,
        input int wb,
        input int wr
    );
        int wmax;
        wmax = (wa > wb) ? wa : wb;
        return (wr >= wmax + 1);
    endfunction

    // Requester index width; never below one bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit num_req_ok(input int n);
        return (n >= NUM_REQ_MIN) && (n <= NUM_REQ_MAX);
    endfunction

endpackage

// File: rtl/add_share_arbiter_rr_grant.sv
// Combinational round-robin picker: first set valid bit at or above ptr.
// Ports: valid_i request vector, ptr_i search start, grant_o one-hot/zero.
module rr_grant
    import mmul_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o
);

    logic          found;
    logic [IW-1:0] idx;

    // Walk N positions starting at ptr_i, wrapping past N-1 to 0.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            int t;
            t = int'(ptr_i) + k;
            if (t >= N) begin
                t = t - N;
            end
            idx = IW'(t);
            if (!found && valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noOverflowAdd.sv
// Registered unsigned adder whose result is wide enough never to wrap.
// Ports: clk_i clock, a_i/b_i operands, sum_o registered a+b (no reset).
module noOverflowAdd #(
    parameter int WIDTH_A   = 32,
    parameter int WIDTH_B   = 32,
    parameter int RES_WIDTH = 37
) (
    input  logic                 clk_i,
    input  logic [WIDTH_A-1:0]   a_i,
    input  logic [WIDTH_B-1:0]   b_i,
    output logic [RES_WIDTH-1:0] sum_o
);

    logic [RES_WIDTH-1:0] sum_q;
    logic [RES_WIDTH-1:0] sum_d;

    // Zero-extend both operands before adding so the carry is kept.
    always_comb begin
        sum_d = RES_WIDTH'(a_i) + RES_WIDTH'(b_i);
    end

    // Datapath register only; validity is tracked by the caller.
    always_ff @(posedge clk_i) begin
        sum_q <= sum_d;
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/add_share_arbiter.sv
// Round-robin front end sharing one registered adder among NUM_REQ rows.
// Ports: Clock/Resetn, enable, req_valid/req_a/req_b in, req_ready out,
// rsp_valid/rsp_id/rsp_sum result two cycles after grant, busy.
module add_share_arbiter
    import mmul_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH_A   = WIDTH_A_DEF,
    parameter int WIDTH_B   = WIDTH_B_DEF,
    parameter int RES_WIDTH = RES_WIDTH_DEF,
    localparam int ID_W     = id_width(NUM_REQ)
) (
    input  logic                       Clock,
    input  logic                       Resetn,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH_A-1:0] req_a,
    input  logic [NUM_REQ*WIDTH_B-1:0] req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    output logic [ID_W-1:0]            rsp_id,
    output logic [RES_WIDTH-1:0]       rsp_sum,
    output logic                       busy
);

    if (!res_width_ok(WIDTH_A, WIDTH_B, RES_WIDTH)) begin : g_bad_width
        $fatal(1, "add_share_arbiter: RES_WIDTH too narrow");
    end

    if (!num_req_ok(NUM_REQ)) begin : g_bad_num
        $fatal(1, "add_share_arbiter: NUM_REQ out of range");
    end

    logic [NUM_REQ-1:0]   pick;
    logic [NUM_REQ-1:0]   grant;
    logic                 xfer;
    logic [ID_W-1:0]      gnt_id;
    logic [WIDTH_A-1:0]   sel_a;
    logic [WIDTH_B-1:0]   sel_b;

    logic [ID_W-1:0]      rr_ptr_q;
    logic [ID_W-1:0]      rr_ptr_d;

    logic [WIDTH_A-1:0]   op_a_q;
    logic [WIDTH_B-1:0]   op_b_q;
    logic [ID_W-1:0]      s1_id_q;
    logic                 s1_valid_q;

    logic [ID_W-1:0]      s2_id_q;
    logic                 s2_valid_q;
    logic [RES_WIDTH-1:0] adder_sum;

    rr_grant #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr_grant (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick)
    );

    // Reset is folded in so ready drops the moment Resetn goes low.
    assign grant     = (enable && Resetn) ? pick : '0;
    assign req_ready = grant;
    assign xfer      = |grant;

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        sel_a = req_a[int'(gnt_id)*WIDTH_A +: WIDTH_A];
        sel_b = req_b[int'(gnt_id)*WIDTH_B +: WIDTH_B];
    end

    // Next search starts just past the winner, wrapping at NUM_REQ.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            if (gnt_id == ID_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_id + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rr_ptr_q   <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            s1_id_q    <= '0;
            s1_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s1_valid_q <= xfer;
            if (xfer) begin
                op_a_q  <= sel_a;
                op_b_q  <= sel_b;
                s1_id_q <= gnt_id;
            end
            s2_valid_q <= s1_valid_q;
            s2_id_q    <= s1_id_q;
        end
    end

    noOverflowAdd #(
        .WIDTH_A   (WIDTH_A),
        .WIDTH_B   (WIDTH_B),
        .RES_WIDTH (RES_WIDTH)
    ) u_add (
        .clk_i (Clock),
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sum_o (adder_sum)
    );

    // The adder register is unreset; gating keeps rsp_sum defined.
    assign rsp_valid = s2_valid_q;
    assign rsp_id    = s2_id_q;
    assign rsp_sum   = s2_valid_q ? adder_sum : '0;
    assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Self-checking bench for add_share_arbiter.
// Directed scenarios with literal expectations, then randomized traffic.
module tb_add_share_arbiter;

    localparam int N  = 4;
    localparam int WA = 32;
    localparam int WB = 32;
    localparam int RW = 37;
    localparam int IW = 2;

    logic            Clock;
    logic            Resetn;
    logic            enable;
    logic [N-1:0]    req_valid;
    logic [N*WA-1:0] req_a;
    logic [N*WB-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic [RW-1:0]   rsp_sum;
    logic            busy;

    add_share_arbiter #(
        .NUM_REQ   (N),
        .WIDTH_A   (WA),
        .WIDTH_B   (WB),
        .RES_WIDTH (RW)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .enable    (enable),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .busy      (busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        int            id;
        logic [RW-1:0] sum;
        int            due;
    } rsp_t;

    rsp_t          q[$];
    bit            pv[N];
    logic [WA-1:0] pa[N];
    logic [WB-1:0] pb[N];
    int            ptr;
    int            cyc;
    bit            en;
    bit            rnd;
    int            checks;
    int            errors;

    logic [N-1:0]  obs_ready;
    logic          obs_valid;
    logic [IW-1:0] obs_id;
    logic [RW-1:0] obs_sum;
    logic          obs_busy;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // First pending requester at or after ptr, with wrap; -1 if none.
    function automatic int model_grant();
        if (!en) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (pv[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive();
        enable = en;
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = pv[i];
            req_a[i*WA +: WA]   = pa[i];
            req_b[i*WB +: WB]   = pb[i];
        end
    endtask

    // One clock cycle: drive, compare against model, advance model.
    task automatic cycle();
        int           g;
        logic [N-1:0] exp_ready;
        if (rnd) begin
            en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i] = 1'b1;
                    pa[i] = $urandom;
                    pb[i] = $urandom;
                    if ($urandom_range(0, 7) == 0) pa[i] = '1;
                    if ($urandom_range(0, 7) == 0) pb[i] = '1;
                end
            end
        end
        drive();
        #1;
        g = model_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        obs_ready = req_ready;
        obs_valid = rsp_valid;
        obs_id    = rsp_id;
        obs_sum   = rsp_sum;
        obs_busy  = busy;
        chk("req_ready", req_ready, exp_ready);
        chk("busy", busy, q.size() > 0);
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_sum", rsp_sum, q[0].sum);
            void'(q.pop_front());
        end else begin
            chk("rsp_valid_idle", rsp_valid, 0);
            chk("rsp_sum_idle", rsp_sum, 0);
        end
        @(posedge Clock);
        if (g >= 0) begin
            q.push_back('{g, RW'(pa[g]) + RW'(pb[g]), cyc + 2});
            pv[g] = 1'b0;
            ptr   = (g + 1) % N;
        end
        cyc++;
        @(negedge Clock);
    endtask

    task automatic fill_all();
        for (int i = 0; i < N; i++) begin
            if (!pv[i]) begin
                pv[i] = 1'b1;
                pa[i] = $urandom;
                pb[i] = $urandom;
            end
        end
    endtask

    logic [N-1:0] order[8];

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        ptr    = 0;
        rnd    = 1'b0;
        en     = 1'b1;
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0;
            pa[i] = '0;
            pb[i] = '0;
        end
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        enable    = 1'b0;
        Resetn    = 1'b0;

        // Reset state with a request pending: nothing may be granted.
        @(negedge Clock);
        pv[0] = 1'b1;
        drive();
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_busy", busy, 0);
        @(negedge Clock);
        pv[0]  = 1'b0;
        drive();
        Resetn = 1'b1;

        // Single request: req 2, 5 + 7.
        pv[2] = 1'b1; pa[2] = 32'd5; pb[2] = 32'd7;
        cycle();
        chk("single_grant", obs_ready, 4'b0100);
        cycle();
        chk("single_busy1", obs_busy, 1);
        cycle();
        chk("single_valid", obs_valid, 1);
        chk("single_id", obs_id, 2);
        chk("single_sum", obs_sum, 37'd12);
        chk("single_busy2", obs_busy, 1);
        cycle();
        chk("single_busy_end", obs_busy, 0);

        // Widest operands: carry must land in bit 32.
        pv[0] = 1'b1; pa[0] = 32'hFFFF_FFFF; pb[0] = 32'hFFFF_FFFF;
        cycle();
        chk("ovf_grant", obs_ready, 4'b0001);
        cycle();
        cycle();
        chk("ovf_sum", obs_sum, 37'h1_FFFF_FFFE);

        // Park the pointer at 0 by granting req 3 alone.
        pv[3] = 1'b1; pa[3] = 32'd1; pb[3] = 32'd2;
        cycle();
        chk("model_ptr0", ptr, 0);

        // Fairness: all valid continuously for 8 cycles.
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                  4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int k = 0; k < 8; k++) begin
            fill_all();
            cycle();
            chk("fair_order", obs_ready, order[k]);
        end

        // Disable with requests pending; in-flight work drains.
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fill_all();
            cycle();
            chk("dis_no_grant", obs_ready, 0);
            chk("dis_drain", obs_valid, k < 2);
        end
        en = 1'b1;
        fill_all();
        cycle();
        chk("reen_grant", obs_ready, 4'b0001);
        fill_all();
        cycle();
        chk("reen_grant2", obs_ready, 4'b0010);

        // Async reset between edges with two ops in flight.
        #2;
        Resetn = 1'b0;
        #1;
        chk("arst_ready", req_ready, 0);
        chk("arst_valid", rsp_valid, 0);
        chk("arst_id", rsp_id, 0);
        chk("arst_sum", rsp_sum, 0);
        chk("arst_busy", busy, 0);
        q.delete();
        ptr = 0;
        for (int i = 0; i < N; i++) pv[i] = 1'b0;
        drive();
        @(posedge Clock);
        cyc++;
        @(negedge Clock);
        Resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("post_rst_quiet", obs_valid, 0);
        end

        // Sparse wrap: pointer to 3, then only req 1 valid.
        pv[2] = 1'b1; pa[2] = 32'd10; pb[2] = 32'd20;
        cycle();
        chk("sparse_g2", obs_ready, 4'b0100);
        pv[1] = 1'b1; pa[1] = 32'd3; pb[1] = 32'd4;
        cycle();
        chk("sparse_g1", obs_ready, 4'b0010);
        chk("model_ptr2", ptr, 2);
        pv[1] = 1'b1; pv[2] = 1'b1; pv[3] = 1'b1;
        cycle();
        chk("sparse_after", obs_ready, 4'b0100);
        for (int k = 0; k < 4; k++) cycle();

        // Randomized traffic against the model.
        rnd = 1'b1;
        for (int k = 0; k < 2000; k++) cycle();
        rnd = 1'b0;
        en  = 1'b0;
        for (int k = 0; k < 4; k++) cycle();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
